c_win_acc: RTL and testbench

//  Parametrised complex multiply + sliding-window accumulator: r+ji = sum of the last WIN valid

---
 rtl/c_win_acc.sv | 196 +++++++++++++++++++
 tb/tb_c_win_acc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/c_win_acc.sv
// Complex multiply followed by a sliding-window sum of the last WIN valid products.
// Optional output saturation and sat_flag port when C_WIN_ACC_SAT_EN is defined.
module c_win_acc #(
   parameter int Q   = 8,
   parameter int N   = 16,
   parameter int WIN = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   input  logic signed [N-1:0] in_ar,
   input  logic signed [N-1:0] in_ai,
   input  logic signed [N-1:0] in_br,
   input  logic signed [N-1:0] in_bi,
   output logic                out_valid,
   output logic signed [N-1:0] r_out,
   output logic signed [N-1:0] i_out,
`ifdef C_WIN_ACC_SAT_EN
   output logic                sat_flag,
`endif
   output logic                win_full
);

   localparam int ACC_W = N + $clog2(WIN) + 1;
   localparam int PW    = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int CW    = $clog2(WIN + 1);

   logic signed [N-1:0]     ar_q, ai_q, br_q, bi_q, ar_d, ai_d, br_d, bi_d;
   logic signed [2*N-1:0]   prr_q, pii_q, pri_q, pir_q, prr_d, pii_d, pri_d, pir_d;
   logic signed [2*N:0]     sr_q, si_q, sr_d, si_d;
   logic signed [N-1:0]     pr_q, pi_q, pr_d, pi_d;
   logic [3:0]              vld_q, vld_d;

   logic signed [ACC_W-1:0] acc_r_q, acc_i_q, acc_r_d, acc_i_d;
   logic [CW-1:0]           count_q, count_d;
   logic [PW-1:0]           wptr_q, wptr_d;
   logic                    out_valid_q, out_valid_d, win_full_q, win_full_d;
   logic signed [N-1:0]     r_out_q, i_out_q, r_out_d, i_out_d;
   logic [2*N-1:0]          buf_q [WIN];
   logic                    buf_we;
   logic signed [N-1:0]     old_r, old_i;

`ifdef C_WIN_ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
   logic sat_q, sat_d;

   function automatic logic over_range(input logic signed [ACC_W-1:0] a);
      return (a > ACC_MAX) || (a < ACC_MIN);
   endfunction

   function automatic logic signed [N-1:0] clamp(input logic signed [ACC_W-1:0] a);
      logic signed [N-1:0] res;
      if (a > ACC_MAX) begin
         res = {1'b0, {(N-1){1'b1}}};
      end else if (a < ACC_MIN) begin
         res = {1'b1, {(N-1){1'b0}}};
      end else begin
         res = a[N-1:0];
      end
      return res;
   endfunction
`endif

   // Multiplier: operands, partial products, full-precision combine, scaled product.
   always_comb begin
      ar_d  = in_ar;
      ai_d  = in_ai;
      br_d  = in_br;
      bi_d  = in_bi;
      prr_d = (2*N)'(ar_q) * (2*N)'(br_q);
      pii_d = (2*N)'(ai_q) * (2*N)'(bi_q);
      pri_d = (2*N)'(ar_q) * (2*N)'(bi_q);
      pir_d = (2*N)'(ai_q) * (2*N)'(br_q);
      sr_d  = (2*N+1)'(prr_q) - (2*N+1)'(pii_q);
      si_d  = (2*N+1)'(pri_q) + (2*N+1)'(pir_q);
      pr_d  = N'(sr_q >>> Q);
      pi_d  = N'(si_q >>> Q);
      if (clr) begin
         vld_d = 4'b0000;
      end else begin
         vld_d = {vld_q[2:0], in_valid};
      end
   end

   // Window update: add the new product and, once full, retire the oldest one.
   always_comb begin
      acc_r_d     = acc_r_q;
      acc_i_d     = acc_i_q;
      count_d     = count_q;
      wptr_d      = wptr_q;
      buf_we      = 1'b0;
      out_valid_d = 1'b0;
      r_out_d     = r_out_q;
      i_out_d     = i_out_q;
      old_r       = buf_q[wptr_q][2*N-1:N];
      old_i       = buf_q[wptr_q][N-1:0];
`ifdef C_WIN_ACC_SAT_EN
      sat_d       = sat_q;
`endif
      if (clr) begin
         acc_r_d = '0;
         acc_i_d = '0;
         count_d = '0;
         wptr_d  = '0;
`ifdef C_WIN_ACC_SAT_EN
         sat_d   = 1'b0;
`endif
      end else if (vld_q[3]) begin
         if (count_q == CW'(WIN)) begin
            acc_r_d = acc_r_q + ACC_W'(pr_q) - ACC_W'(old_r);
            acc_i_d = acc_i_q + ACC_W'(pi_q) - ACC_W'(old_i);
         end else begin
            acc_r_d = acc_r_q + ACC_W'(pr_q);
            acc_i_d = acc_i_q + ACC_W'(pi_q);
            count_d = count_q + CW'(1);
         end
         buf_we = 1'b1;
         if (wptr_q == PW'(WIN - 1)) begin
            wptr_d = '0;
         end else begin
            wptr_d = wptr_q + PW'(1);
         end
         if (count_d == CW'(WIN)) begin
            out_valid_d = 1'b1;
`ifdef C_WIN_ACC_SAT_EN
            r_out_d = clamp(acc_r_d);
            i_out_d = clamp(acc_i_d);
            sat_d   = over_range(acc_r_d) || over_range(acc_i_d);
`else
            r_out_d = acc_r_d[N-1:0];
            i_out_d = acc_i_d[N-1:0];
`endif
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         buf_we = 1'b0;
      end
      win_full_d = (count_d == CW'(WIN));
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar_q <= '0; ai_q <= '0; br_q <= '0; bi_q <= '0;
         prr_q <= '0; pii_q <= '0; pri_q <= '0; pir_q <= '0;
         sr_q <= '0; si_q <= '0; pr_q <= '0; pi_q <= '0;
         vld_q       <= 4'b0000;
         acc_r_q     <= '0;
         acc_i_q     <= '0;
         count_q     <= '0;
         wptr_q      <= '0;
         out_valid_q <= 1'b0;
         win_full_q  <= 1'b0;
         r_out_q     <= '0;
         i_out_q     <= '0;
`ifdef C_WIN_ACC_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         ar_q <= ar_d; ai_q <= ai_d; br_q <= br_d; bi_q <= bi_d;
         prr_q <= prr_d; pii_q <= pii_d; pri_q <= pri_d; pir_q <= pir_d;
         sr_q <= sr_d; si_q <= si_d; pr_q <= pr_d; pi_q <= pi_d;
         vld_q       <= vld_d;
         acc_r_q     <= acc_r_d;
         acc_i_q     <= acc_i_d;
         count_q     <= count_d;
         wptr_q      <= wptr_d;
         out_valid_q <= out_valid_d;
         win_full_q  <= win_full_d;
         r_out_q     <= r_out_d;
         i_out_q     <= i_out_d;
`ifdef C_WIN_ACC_SAT_EN
         sat_q       <= sat_d;
`endif
      end
   end

   // Product history; stale entries beyond count are never read.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_q[wptr_q] <= {pr_q, pi_q};
      end
   end

   assign out_valid = out_valid_q;
   assign r_out     = r_out_q;
   assign i_out     = i_out_q;
   assign win_full  = win_full_q;
`ifdef C_WIN_ACC_SAT_EN
   assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_c_win_acc.sv
// Scoreboard bench for c_win_acc: random and directed stimulus against a queue-based window model.
module tb_c_win_acc;
   localparam int Q = 8, N = 16, WIN = 4;

   logic clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0;
   logic signed [N-1:0] in_ar = '0, in_ai = '0, in_br = '0, in_bi = '0;
   logic out_valid, win_full;
   logic signed [N-1:0] r_out, i_out;
`ifdef C_WIN_ACC_SAT_EN
   logic sat_flag;
`endif

   c_win_acc #(.Q(Q), .N(N), .WIN(WIN)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
      .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
      .out_valid(out_valid), .r_out(r_out), .i_out(i_out),
`ifdef C_WIN_ACC_SAT_EN
      .sat_flag(sat_flag),
`endif
      .win_full(win_full)
   );

   always #5 clk = ~clk;

   typedef struct { int r; int i; int e; bit sat; } exp_t;
   typedef struct { int r; int i; int due; } pend_t;
   exp_t  expq[$];
   pend_t pend[$];
   int    win_r[$], win_i[$];
   bit    exp_full = 1'b0, exp_sat = 1'b0, mon_en = 1'b0;
   int    total = 0, bad = 0, edge_n = 0;

   function automatic int wrapn(input longint x);
      logic signed [N-1:0] t;
      t = x[N-1:0];
      return int'(t);
   endfunction

   // Complex product component: (p1*p2 -/+ p3*p4) scaled by 2^-Q with floor, wrapped to N bits.
   function automatic int cprod(input int a, input int b, input int c, input int d, input bit sub);
      longint x;
      if (sub) x = longint'(a) * longint'(b) - longint'(c) * longint'(d);
      else     x = longint'(a) * longint'(b) + longint'(c) * longint'(d);
      return wrapn(x >>> Q);
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, req, edge_n);
      end
   endtask

   function automatic void model_clear();
      win_r.delete(); win_i.delete(); pend.delete(); expq.delete();
      exp_full = 1'b0; exp_sat = 1'b0;
   endfunction

   // One clock: drive inputs, step the reference model at the rising edge, return at the falling edge.
   task automatic tick(input bit v, input int ar, input int ai, input int br, input int bi, input bit c);
      pend_t p;
      exp_t  e;
      longint sr, si;
      in_valid = v; clr = c;
      in_ar = N'(ar); in_ai = N'(ai); in_br = N'(br); in_bi = N'(bi);
      @(posedge clk);
      edge_n++;
      if (c) begin
         model_clear();
      end else begin
         if (pend.size() > 0 && pend[0].due == edge_n) begin
            p = pend.pop_front();
            win_r.push_back(p.r);
            win_i.push_back(p.i);
            if (win_r.size() > WIN) begin
               void'(win_r.pop_front());
               void'(win_i.pop_front());
            end
            if (win_r.size() == WIN) begin
               sr = 0; si = 0;
               foreach (win_r[k]) begin sr += win_r[k]; si += win_i[k]; end
`ifdef C_WIN_ACC_SAT_EN
               e.sat = (sr > 32767) || (sr < -32768) || (si > 32767) || (si < -32768);
               e.r = (sr > 32767) ? 32767 : (sr < -32768) ? -32768 : int'(sr);
               e.i = (si > 32767) ? 32767 : (si < -32768) ? -32768 : int'(si);
`else
               e.sat = 1'b0;
               e.r = wrapn(sr);
               e.i = wrapn(si);
`endif
               e.e = edge_n;
               exp_sat = e.sat;
               expq.push_back(e);
            end
         end
         exp_full = (win_r.size() == WIN);
         if (v) begin
            p.r = cprod(ar, br, ai, bi, 1'b1);
            p.i = cprod(ar, bi, ai, br, 1'b0);
            p.due = edge_n + 4;
            pend.push_back(p);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, 0, 0, 0, 0, 1'b0);
   endtask

   // Monitor: compares every DUT output against the scoreboard once per cycle.
   always @(negedge clk) begin
      exp_t e;
      bit   due;
      if (mon_en && !rst) begin
         check("win_full", win_full, exp_full);
`ifdef C_WIN_ACC_SAT_EN
         check("sat_flag", sat_flag, exp_sat);
`endif
         due = (expq.size() > 0) && (expq[0].e == edge_n);
         check("out_valid", out_valid, due);
         if (due) begin
            e = expq.pop_front();
            if (out_valid) begin
               check("r_out", r_out, e.r);
               check("i_out", i_out, e.i);
            end
         end
      end
   end

   initial begin
      int gap;
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_r_out", r_out, 0);
      check("rst_i_out", i_out, 0);
      check("rst_win_full", win_full, 0);
      rst = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // 1 and 2: fill the window, then push one zero product to retire the oldest.
      for (int k = 0; k < 4; k++) tick(1'b1, 256, 0, 512, 256, 1'b0);
      idle(5);
      check("t1_r", r_out, 2048);
      check("t1_i", i_out, 1024);
      check("t1_full", win_full, 1);
      tick(1'b1, 0, 0, 512, 256, 1'b0);
      idle(5);
      check("t2_r", r_out, 1536);
      check("t2_i", i_out, 768);

      // 3: gapped inputs from an empty window.
      tick(1'b0, 0, 0, 0, 0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick(1'b1, 256, 256, 256, -256, 1'b0);
         gap = $urandom_range(0, 3);
         idle(gap);
      end
      idle(6);
      check("t3_r", r_out, 2048);
      check("t3_i", i_out, 0);

      // 4: overflow of the N-bit output range.
      tick(1'b0, 0, 0, 0, 0, 1'b1);
      for (int k = 0; k < 4; k++) tick(1'b1, 32767, 0, 256, 0, 1'b0);
      idle(5);
`ifdef C_WIN_ACC_SAT_EN
      check("t4_r_sat", r_out, 32767);
      check("t4_flag", sat_flag, 1);
`else
      check("t4_r_wrap", r_out, -4);
`endif

      // 5: clear with in-flight data and a same-cycle input, then a fresh window.
      for (int k = 0; k < 3; k++) tick(1'b1, 1000, -700, 3000, 1234, 1'b0);
      tick(1'b1, 1000, -700, 3000, 1234, 1'b1);
      for (int k = 0; k < 4; k++) tick(1'b1, 256, 0, 256, 0, 1'b0);
      idle(5);
      check("t5_r", r_out, 1024);
      check("t5_i", i_out, 0);

      // Random traffic with occasional clears.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0)
            tick(1'b1, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                 $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                 $urandom_range(0, 49) == 0);
         else
            tick($urandom_range(0, 4) != 0, $urandom_range(0, 2047) - 1024,
                 $urandom_range(0, 2047) - 1024, $urandom_range(0, 2047) - 1024,
                 $urandom_range(0, 2047) - 1024, $urandom_range(0, 49) == 0);
      end

      // 6: asynchronous reset with two products in flight and a full window.
      for (int k = 0; k < 6; k++) tick(1'b1, 300, 100, 256, -50, 1'b0);
      idle(2);
      tick(1'b1, 700, 0, 256, 0, 1'b0);
      tick(1'b1, 700, 0, 256, 0, 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("t6_out_valid", out_valid, 0);
      check("t6_r", r_out, 0);
      check("t6_i", i_out, 0);
      check("t6_full", win_full, 0);
      model_clear();
      #1 rst = 1'b0;
      idle(8);
      for (int k = 0; k < 4; k++) tick(1'b1, 512, 0, 256, 256, 1'b0);
      idle(6);
      check("t6_restart_r", r_out, 2048);
      check("t6_restart_i", i_out, 2048);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
